// File: rtl/reg_serializer.sv
// Parallel-in/serial-out readout register: loads a WIDTH-bit word over a valid/ready
// handshake, shifts it out one bit per accepted beat and pulses word_done per word.
module reg_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_last,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;
  logic             in_shift;
  logic             last_bit;
  logic             load_fire;

  // Advance the word one place toward the output end, zero-filled.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v);
    if (MSB_FIRST)
      shift_step = {v[WIDTH-2:0], 1'b0};
    else
      shift_step = {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST)
      out_bit = v[WIDTH-1];
    else
      out_bit = v[0];
  endfunction

  assign in_shift = (state == SHIFT);
  assign last_bit = in_shift && (cnt == LAST_CNT);

  // A new word may enter while idle, or on the edge that retires the final bit.
  assign load_ready = !rst && (!in_shift || (last_bit && ser_ready));
  assign load_fire  = load_valid && load_ready;

  assign ser_valid = in_shift;
  assign busy      = in_shift;
  assign ser_last  = last_bit;
  assign ser_out   = in_shift && out_bit(shift_reg);

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load_fire) begin
          state_nxt = SHIFT;
          shift_nxt = data_in;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (last_bit) begin
            done_nxt = 1'b1;
            if (load_fire) begin
              shift_nxt = data_in;
              cnt_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            shift_nxt = shift_step(shift_reg);
            cnt_nxt   = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      cnt       <= cnt_nxt;
      word_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_reg_serializer.sv
// Directed bench for reg_serializer: MSB-first and LSB-first instances driven in lockstep.
module tb_reg_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       ser_ready;
  logic [7:0] data_in;

  logic m_load_ready, m_ser_valid, m_ser_out, m_ser_last, m_word_done, m_busy;
  logic l_load_ready, l_ser_valid, l_ser_out, l_ser_last, l_word_done, l_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(m_load_ready),
    .data_in(data_in), .ser_valid(m_ser_valid), .ser_ready(ser_ready),
    .ser_out(m_ser_out), .ser_last(m_ser_last), .word_done(m_word_done), .busy(m_busy)
  );

  reg_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_load_ready),
    .data_in(data_in), .ser_valid(l_ser_valid), .ser_ready(ser_ready),
    .ser_out(l_ser_out), .ser_last(l_ser_last), .word_done(l_word_done), .busy(l_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    int idx;

    rst = 1'b1; load_valid = 1'b0; ser_ready = 1'b0; data_in = 8'h00;
    #1;
    chk("rst_ser_valid", m_ser_valid, 0);
    chk("rst_ser_out", m_ser_out, 0);
    chk("rst_ser_last", m_ser_last, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_load_ready", m_load_ready, 0);
    chk("rst_word_done", m_word_done, 0);
    tick();
    load_valid = 1'b1; data_in = 8'hC1; ser_ready = 1'b1;
    tick();
    chk("rst_no_load_valid", m_ser_valid, 0);
    chk("rst_no_load_ready", l_load_ready, 0);
    rst = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("post_rst_load_ready", m_load_ready, 1);

    // MSB-first and LSB-first serialisation of 8'hC1
    w = 8'hC1;
    data_in = w; load_valid = 1'b1; ser_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_valid%0d", i), m_ser_valid, 1);
      chk($sformatf("t1_msb_bit%0d", i), m_ser_out, w[7-i]);
      chk($sformatf("t1_lsb_bit%0d", i), l_ser_out, w[i]);
      chk($sformatf("t1_last%0d", i), m_ser_last, (i == 7));
      chk($sformatf("t1_lsb_last%0d", i), l_ser_last, (i == 7));
      chk($sformatf("t1_done%0d", i), m_word_done, 0);
      if (i == 0) load_valid = 1'b0;
      tick();
    end
    chk("t1_done_pulse", m_word_done, 1);
    chk("t1_lsb_done_pulse", l_word_done, 1);
    chk("t1_valid_end", m_ser_valid, 0);
    chk("t1_load_ready_back", m_load_ready, 1);
    tick();
    chk("t1_done_clear", m_word_done, 0);

    // Backpressure on 8'h5A: three stall cycles while bit index 3 is presented
    w = 8'h5A;
    data_in = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      idx = (c < 3) ? c : ((c < 7) ? 3 : c - 3);
      ser_ready = !(c >= 3 && c < 6);
      chk($sformatf("t3_valid_c%0d", c), m_ser_valid, 1);
      chk($sformatf("t3_bit_c%0d", c), m_ser_out, w[7-idx]);
      chk($sformatf("t3_last_c%0d", c), m_ser_last, (idx == 7));
      tick();
    end
    chk("t3_done_pulse", m_word_done, 1);
    chk("t3_valid_end", m_ser_valid, 0);
    tick();

    // Back-to-back 8'hC1 then 8'h5A with load_valid held
    data_in = 8'hC1; load_valid = 1'b1; ser_ready = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      w = (c <= 8) ? 8'hC1 : 8'h5A;
      idx = (c - 1) % 8;
      chk($sformatf("t4_valid_c%0d", c), m_ser_valid, 1);
      chk($sformatf("t4_bit_c%0d", c), m_ser_out, w[7-idx]);
      chk($sformatf("t4_last_c%0d", c), m_ser_last, (idx == 7));
      chk($sformatf("t4_done_c%0d", c), m_word_done, (c == 9));
      chk($sformatf("t4_load_ready_c%0d", c), m_load_ready, (idx == 7));
      if (c == 1) data_in = 8'h5A;
      if (c == 9) load_valid = 1'b0;
      tick();
    end
    chk("t4_done_c17", m_word_done, 1);
    chk("t4_valid_c17", m_ser_valid, 0);
    tick();

    // Load attempts while busy are ignored; pending 8'hFF enters at the last-bit edge
    data_in = 8'h00; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        data_in = 8'hFF;
        load_valid = 1'b1;
      end
      chk($sformatf("t5_zero_bit%0d", i), m_ser_out, 0);
      chk($sformatf("t5_load_ready%0d", i), m_load_ready, (i == 7));
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      if (j == 0) begin
        chk("t5_done_first", m_word_done, 1);
        load_valid = 1'b0;
      end
      chk($sformatf("t5_ff_valid%0d", j), m_ser_valid, 1);
      chk($sformatf("t5_ff_bit%0d", j), m_ser_out, 1);
      tick();
    end
    chk("t5_done_second", m_word_done, 1);
    chk("t5_valid_end", m_ser_valid, 0);
    tick();

    // Asynchronous reset during bit 4 of 8'hAA, then a fresh 8'h81
    w = 8'hAA;
    data_in = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_bit%0d", i), m_ser_out, w[7-i]);
      tick();
    end
    chk("t6_bit4_before_rst", m_ser_out, 1);
    chk("t6_valid_before_rst", m_ser_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", m_ser_valid, 0);
    chk("t6_rst_out", m_ser_out, 0);
    chk("t6_rst_load_ready", m_load_ready, 0);
    chk("t6_rst_busy", m_busy, 0);
    tick();
    chk("t6_rst_no_done", m_word_done, 0);
    rst = 1'b0;
    #1;
    chk("t6_release_load_ready", m_load_ready, 1);
    chk("t6_release_valid", m_ser_valid, 0);
    tick();
    chk("t6_idle_no_done", m_word_done, 0);
    chk("t6_idle_valid", m_ser_valid, 0);
    w = 8'h81;
    data_in = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6_fresh_bit%0d", i), m_ser_out, w[7-i]);
      chk($sformatf("t6_fresh_lsb_bit%0d", i), l_ser_out, w[i]);
      chk($sformatf("t6_fresh_last%0d", i), m_ser_last, (i == 7));
      tick();
    end
    chk("t6_fresh_done", m_word_done, 1);
    chk("t6_fresh_valid_end", m_ser_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_serializer.md
# reg_serializer

Parallel-in/serial-out readout register for the flip-flop register file. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per accepted beat on a valid/ready serial port. It then reports completion of each word. It is the read-side counterpart of the 8-bit parallel-load register: words stored there are drained through this block to a one-bit link.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  upstream word present on data_in.
- load_ready  output  1  block can accept a word this cycle.
- data_in  input  WIDTH  word to serialize; sampled only on a load handshake.
- ser_valid  output  1  ser_out carries a valid bit.
- ser_ready  input  1  downstream accepts the current bit at this edge.
- ser_out  output  1  current serial bit.
- ser_last  output  1  current bit is the final bit of the word.
- word_done  output  1  one-cycle pulse after the final bit of a word is accepted.
- busy  output  1  a word is in flight (state SHIFT).

## Operation
- Reset: asynchronous and active-high; one clock.
- Registered state:
  - state: IDLE or SHIFT.
  - shift register of WIDTH bits.
  - bit counter of ceil(log2(WIDTH)) bits.
  - word_done flop.
- While rst is high, and on its assertion:
  - state=IDLE, shift register=0, counter=0, word_done=0.
  - Outputs: ser_valid=0, ser_out=0, ser_last=0, busy=0, load_ready=0.
- Output decode:
  - load_ready = !rst && (state==IDLE || (state==SHIFT && ser_last && ser_ready)).
  - ser_valid = busy = (state==SHIFT).
  - ser_last = (state==SHIFT && counter==WIDTH-1).
  - ser_out = shift[WIDTH-1] when MSB_FIRST=1, shift[0] when MSB_FIRST=0. It is forced to 0 in IDLE.
- IDLE → SHIFT on load_valid && load_ready. On that transition:
  - shift register ← data_in.
  - counter ← 0.
- In SHIFT with ser_ready=1:
  - If not the last bit: counter +1, and the shift register moves one place toward the output end (left for MSB_FIRST, right otherwise), zero-filled.
  - If ser_last: word_done is set for the next cycle.
    - If load_valid is also 1, the new word loads and the block stays in SHIFT with counter=0 (no gap).
    - Otherwise the next state is IDLE.
- In SHIFT with ser_ready=0: all state holds. ser_out and ser_last stay stable.
- load_valid while busy (not on the last accepted bit) is ignored. data_in has no effect.
- word_done is high for exactly one cycle per completed word, including back-to-back words.
- Reset mid-word: the word is aborted, with no word_done and no further ser_valid until the next load.

## Timing
- Load latency: the load is accepted at edge N, and the first bit is valid from edge N to edge N+1.
- With ser_ready held at 1:
  - ser_valid is high for exactly WIDTH consecutive cycles.
  - ser_last is high in the WIDTH-th of those cycles.
  - word_done is high in the cycle after the final acceptance edge.
- Throughput: one bit per cycle. Back-to-back words give WIDTH·k contiguous valid cycles for k words.
- load_ready depends combinationally on ser_ready in the last-bit cycle only. There is no combinational path from load_valid or data_in to any output.
- ser_out, ser_valid, ser_last and busy derive only from registered state (plus rst). They are glitch-free relative to downstream inputs.

## Test plan
- Reset then load 8'hC1, MSB_FIRST=1, ser_ready=1:
  - ser_out over 8 cycles is 1,1,0,0,0,0,0,1.
  - ser_last only on cycle 8; word_done on cycle 9.
  - load_ready returns to 1 in cycle 9.
- MSB_FIRST=0, load 8'hC1: ser_out is 1,0,0,0,0,0,1,1.
- Backpressure: load 8'h5A, drop ser_ready for 3 cycles while bit index 3 is presented.
  - ser_out and ser_last hold for those 3 cycles.
  - Full sequence is 0,1,0,1,1,0,1,0, completing in 11 cycles.
- Back-to-back: 8'hC1 then 8'h5A with load_valid held and ser_ready=1.
  - 16 contiguous ser_valid cycles.
  - ser_last on cycles 8 and 16; load_ready high in cycle 8.
  - word_done pulses in cycles 9 and 17.
- Busy load ignored: change data_in to 8'hFF with load_valid=1 during bits 2..5 of 8'h00.
  - Output stays all zeros; load_ready=0 over those cycles.
  - The pending 8'hFF loads only at the last-bit edge.
- Reset mid-word: assert rst asynchronously (between edges) during bit 4 of 8'hAA.
  - ser_valid, ser_out and load_ready go 0 immediately; no word_done.
  - After release, load_ready=1 and a fresh 8'h81 serializes correctly.
